mem_port_arbiter: RTL and testbench

Round-robin arbiter sharing one port of the dual-port Hamming/banked memory among NUM_REQ requesters. Each requester issues single-word read or write commands with a req/gnt handshake; the arbiter drives the memory port's enable, write-enable, address and data, and routes read data back to the issuing requester after the port's read latency. One instance sits in front of each memory port, in that port's clock domain.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter that shares one memory port among NUM_REQ requesters.
// A winner picked in one cycle is driven onto the memory port in the next
// cycle together with a one-cycle grant pulse. Read and write commands are
// tracked in separate {valid, id} shift registers so that read data and
// write completions are returned to the requester that issued them.
// Optional feature macro: ARB_WR_FIRST_EN -- when defined, eligible writes
// take priority over eligible reads (round-robin within the writes).
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_din,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic [NUM_REQ-1:0]            o_wdone,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_din,
    input  logic [DATA_WIDTH-1:0]         i_mem_dout
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       gnt_id;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    cand;
    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [NUM_REQ-1:0]    win_onehot;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_din;

    logic                  cmd_rd;
    logic                  cmd_wr;

    // Stage 0 of each tracking pipeline is the command on the port this
    // cycle; stage k (k >= 1) is that command k cycles later.
    logic [RD_LATENCY-1:0]           rd_vld_q;
    logic [RD_LATENCY-1:0][ID_W-1:0] rd_id_q;
    logic [RD_LATENCY:0]             rd_stage_vld;
    logic [RD_LATENCY:0][ID_W-1:0]   rd_stage_id;
    logic [WR_LATENCY-1:0]           wr_vld_q;
    logic [WR_LATENCY-1:0][ID_W-1:0] wr_id_q;
    logic [WR_LATENCY:0]             wr_stage_vld;
    logic [WR_LATENCY:0][ID_W-1:0]   wr_stage_id;

    // The requester granted this cycle is masked so a held request is not granted twice.
    assign eligible = i_req & ~o_gnt;

    // Candidate set: writes only when write-priority is enabled and any write is pending.
`ifdef ARB_WR_FIRST_EN
    always_comb begin
        cand = eligible;
        if (|(eligible & i_req_we)) begin
            cand = eligible & i_req_we;
        end
    end
`else
    always_comb begin
        cand = eligible;
    end
`endif

    // Round-robin search: first candidate at or after ptr, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!win_found && cand[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    // Select the winning requester's command fields.
    always_comb begin
        win_onehot = '0;
        win_we     = 1'b0;
        win_addr   = '0;
        win_din    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_id == ID_W'(k)) begin
                win_onehot[k] = win_found;
                win_we        = i_req_we[k];
                win_addr      = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                win_din       = i_req_din[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Register grant, pointer and memory command; address/data hold when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_gnt      <= '0;
            gnt_id     <= '0;
            ptr        <= '0;
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
        end else begin
            o_gnt    <= win_onehot;
            o_mem_en <= win_found;
            if (win_found) begin
                gnt_id     <= win_id;
                o_mem_we   <= win_we;
                o_mem_addr <= win_addr;
                o_mem_din  <= win_din;
                if (win_id == ID_W'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= win_id + ID_W'(1);
                end
            end
        end
    end

    assign cmd_rd = o_mem_en & ~o_mem_we;
    assign cmd_wr = o_mem_en & o_mem_we;

    assign rd_stage_vld = {rd_vld_q, cmd_rd};
    assign rd_stage_id  = {rd_id_q, gnt_id};
    assign wr_stage_vld = {wr_vld_q, cmd_wr};
    assign wr_stage_id  = {wr_id_q, gnt_id};

    // Advance the read and write tracking pipelines by one stage per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_vld_q <= '0;
            rd_id_q  <= '0;
            wr_vld_q <= '0;
            wr_id_q  <= '0;
        end else begin
            rd_vld_q <= rd_stage_vld[RD_LATENCY-1:0];
            rd_id_q  <= rd_stage_id[RD_LATENCY-1:0];
            wr_vld_q <= wr_stage_vld[WR_LATENCY-1:0];
            wr_id_q  <= wr_stage_id[WR_LATENCY-1:0];
        end
    end

    // Capture memory read data one cycle before the read response is flagged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (rd_stage_vld[RD_LATENCY-1]) begin
            o_rdata <= i_mem_dout;
        end
    end

    // Decode the final pipeline stage into per-requester response pulses.
    always_comb begin
        o_rvalid = '0;
        o_wdone  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_rvalid[k] = rd_stage_vld[RD_LATENCY] && (rd_stage_id[RD_LATENCY] == ID_W'(k));
            o_wdone[k]  = wr_stage_vld[WR_LATENCY] && (wr_stage_id[WR_LATENCY] == ID_W'(k));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with default parameters (4 requesters,
// RD_LATENCY=2, WR_LATENCY=1). A behavioural memory drives i_mem_dout one
// cycle after a read command is on the port. Expected values honour
// ARB_WR_FIRST_EN when the bench is built with it.
module tb_mem_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_din;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic [NR-1:0]    wdone;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_din;
    logic [DW-1:0]    mem_dout;

    logic [DW-1:0]    mem [0:(1<<AW)-1];
    logic             pl_en;
    logic [AW-1:0]    pl_addr;
    logic [DW-1:0]    pl_data;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .WR_LATENCY(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_din(req_din), .o_gnt(gnt),
        .o_rvalid(rvalid), .o_rdata(rdata), .o_wdone(wdone),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_din(mem_din), .i_mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: preload port, synchronous write, one-stage read register.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[k]               = 1'b1;
        req_we[k]            = we;
        req_addr[k*AW +: AW] = a;
        req_din[k*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    logic [NR-1:0] exp_gnt;
    logic [NR-1:0] exp_rv;
    logic [NR-1:0] first_gnt;
    logic [NR-1:0] second_gnt;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_we   = '0;
        req_addr = '0;
        req_din  = '0;
        pl_en    = 1'b0;
        pl_addr  = '0;
        pl_data  = '0;
        mem_dout = '0;
        #2;
        check_eq("rst_gnt", {60'd0, gnt}, 64'd0);
        check_eq("rst_mem_en", {63'd0, mem_en}, 64'd0);
        check_eq("rst_rdata", {32'd0, rdata}, 64'd0);
        preload(10'h005, 32'hDEADBEEF);
        for (int k = 0; k < NR; k++) preload(10'h010 + 10'(k), 32'hA000_0000 + 32'(k));

        // Single read by requester 2
        do_reset();
        set_req(2, 1'b0, 10'h005, 32'd0);
        tick();
        check_eq("rd1_gnt", {60'd0, gnt}, 64'h4);
        check_eq("rd1_en", {63'd0, mem_en}, 64'd1);
        check_eq("rd1_addr", {54'd0, mem_addr}, 64'h005);
        req[2] = 1'b0;
        tick();
        check_eq("rd1_gnt_off", {60'd0, gnt}, 64'd0);
        check_eq("rd1_en_off", {63'd0, mem_en}, 64'd0);
        check_eq("rd1_rv_early", {60'd0, rvalid}, 64'd0);
        tick();
        check_eq("rd1_rvalid", {60'd0, rvalid}, 64'h4);
        check_eq("rd1_rdata", {32'd0, rdata}, 64'hDEADBEEF);
        tick();
        check_eq("rd1_rv_end", {60'd0, rvalid}, 64'd0);
        check_eq("rd1_rdata_hold", {32'd0, rdata}, 64'hDEADBEEF);

        // All four read continuously
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b0, 10'h010 + 10'(k), 32'd0);
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp_gnt = (n <= 8) ? (4'b0001 << ((n - 1) % 4)) : 4'b0000;
            exp_rv  = (n >= 3) ? (4'b0001 << ((n - 3) % 4)) : 4'b0000;
            check_eq($sformatf("rr_gnt_c%0d", n), {60'd0, gnt}, {60'd0, exp_gnt});
            check_eq($sformatf("rr_rvalid_c%0d", n), {60'd0, rvalid}, {60'd0, exp_rv});
            if (n <= 8) check_eq($sformatf("rr_addr_c%0d", n), {54'd0, mem_addr}, 64'h010 + 64'((n - 1) % 4));
            if (n >= 3) check_eq($sformatf("rr_rdata_c%0d", n), {32'd0, rdata}, 64'hA000_0000 + 64'((n - 3) % 4));
            if (n == 8) req = '0;
        end

        // Write then read back through another requester
        do_reset();
        set_req(1, 1'b1, 10'h3FF, 32'h12345678);
        tick();
        check_eq("wr_gnt", {60'd0, gnt}, 64'h2);
        check_eq("wr_we", {63'd0, mem_we}, 64'd1);
        check_eq("wr_din", {32'd0, mem_din}, 64'h12345678);
        req[1] = 1'b0;
        tick();
        check_eq("wr_wdone", {60'd0, wdone}, 64'h2);
        set_req(3, 1'b0, 10'h3FF, 32'd0);
        tick();
        check_eq("wrrd_gnt", {60'd0, gnt}, 64'h8);
        check_eq("wrrd_wdone_off", {60'd0, wdone}, 64'd0);
        req[3] = 1'b0;
        tick();
        tick();
        check_eq("wrrd_rvalid", {60'd0, rvalid}, 64'h8);
        check_eq("wrrd_rdata", {32'd0, rdata}, 64'h12345678);

        // Withdraw requester 1 before it is granted
        do_reset();
        set_req(0, 1'b0, 10'h011, 32'd0);
        set_req(1, 1'b0, 10'h022, 32'd0);
        tick();
        check_eq("wd_gnt0", {60'd0, gnt}, 64'h1);
        req = '0;
        tick();
        check_eq("wd_gnt_none", {60'd0, gnt}, 64'd0);
        check_eq("wd_en_none", {63'd0, mem_en}, 64'd0);
        check_eq("wd_addr_hold", {54'd0, mem_addr}, 64'h011);
        tick();
        check_eq("wd_gnt_none2", {60'd0, gnt}, 64'd0);
        check_eq("wd_rvalid0", {60'd0, rvalid}, 64'h1);

        // Reset while a read is in flight
        do_reset();
        set_req(2, 1'b0, 10'h005, 32'd0);
        tick();
        check_eq("mr_gnt", {60'd0, gnt}, 64'h4);
        req[2] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mr_rst_rvalid", {60'd0, rvalid}, 64'd0);
        check_eq("mr_rst_addr", {54'd0, mem_addr}, 64'd0);
        check_eq("mr_rst_en", {63'd0, mem_en}, 64'd0);
        check_eq("mr_rst_rdata", {32'd0, rdata}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        set_req(0, 1'b0, 10'h005, 32'd0);
        set_req(3, 1'b0, 10'h013, 32'd0);
        tick();
        check_eq("mr_post_gnt0", {60'd0, gnt}, 64'h1);
        check_eq("mr_post_rv1", {60'd0, rvalid}, 64'd0);
        req[0] = 1'b0;
        tick();
        check_eq("mr_post_gnt3", {60'd0, gnt}, 64'h8);
        check_eq("mr_post_rv2", {60'd0, rvalid}, 64'd0);
        req[3] = 1'b0;
        tick();
        check_eq("mr_post_rv3", {60'd0, rvalid}, 64'h1);
        check_eq("mr_post_rdata", {32'd0, rdata}, 64'hDEADBEEF);

        // Read on 0 and write on 1 at the same time, ptr = 0
`ifdef ARB_WR_FIRST_EN
        first_gnt  = 4'b0010;
        second_gnt = 4'b0001;
`else
        first_gnt  = 4'b0001;
        second_gnt = 4'b0010;
`endif
        do_reset();
        set_req(0, 1'b0, 10'h020, 32'd0);
        set_req(1, 1'b1, 10'h021, 32'h0000_0055);
        tick();
        check_eq("wf_first", {60'd0, gnt}, {60'd0, first_gnt});
        req = req & ~gnt;
        tick();
        check_eq("wf_second", {60'd0, gnt}, {60'd0, second_gnt});
        req = '0;
        tick();
        check_eq("wf_idle", {60'd0, gnt}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
